svc_rv_io_uart_tx: RTL

Memory-mapped UART transmitter that responds to the RISC-V SoC's MMIO initiator bus (`io_ren`/`io_raddr`/`io_rdata`, `io_wen`/`io_waddr`/`io_wdata`/`io_wstrb`). The SoC writes bytes into a TX FIFO, polls status, and sets the baud divisor. A serializer drains the FIFO onto a single `txd` line as 8N1 frames. The block sits beside the SoC on the IO bus in place of the plain IO BRAM, behind an external address decoder.

---
 rtl/svc_rv_io_uart_tx.sv | 207 ++++++++++++++++++++
 1 files changed

// File: rtl/svc_rv_io_uart_tx.sv
// MMIO UART transmitter: TX FIFO, status/divisor registers and an 8N1 serializer.
// txd is registered, so the line lags the serializer state by one cycle.
module svc_rv_io_uart_tx #(
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned DIV_RESET  = 868,
    parameter int unsigned DIV_W      = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        io_ren,
    input  logic [31:0] io_raddr,
    output logic [31:0] io_rdata,
    input  logic        io_wen,
    input  logic [31:0] io_waddr,
    input  logic [31:0] io_wdata,
    input  logic [3:0]  io_wstrb,
    output logic        txd,
    output logic        tx_busy
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = AW + 1;

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StStart = 2'd1;
    localparam logic [1:0] StData  = 2'd2;
    localparam logic [1:0] StStop  = 2'd3;

    logic [7:0]       mem [FIFO_DEPTH];
    logic [AW-1:0]    wptr_q, rptr_q;
    logic [CW-1:0]    count_q, count_d;
    logic             ovf_q, ovf_d;
    logic [DIV_W-1:0] div_q, div_d, div_eff;
    logic [1:0]       state_q, state_d;
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shift_q, shift_d;
    logic             txd_q, txd_d;
    logic [31:0]      rdata_q, rdata_d;

    logic full, empty, push, pop, last;
    logic wr_data, wr_ovf_clr, wr_div;
    logic [31:0] status;

    assign full    = (count_q == CW'(FIFO_DEPTH));
    assign empty   = (count_q == '0);
    assign div_eff = (div_q == '0) ? DIV_W'(1) : div_q;
    assign last    = (cnt_q <= DIV_W'(1));

    assign wr_data    = io_wen && (io_waddr[3:2] == 2'd0) && io_wstrb[0];
    assign wr_ovf_clr = io_wen && (io_waddr[3:2] == 2'd1) && io_wstrb[0] && io_wdata[3];
    assign wr_div     = io_wen && (io_waddr[3:2] == 2'd2);
    assign push       = wr_data && !full;

    assign tx_busy = (state_q != StIdle) || !empty;
    assign status  = {28'd0, ovf_q, tx_busy, empty, full};
    assign txd      = txd_q;
    assign io_rdata = rdata_q;

    // Clear has priority over a same-cycle overflow.
    always_comb begin
        ovf_d = ovf_q;
        if (wr_ovf_clr) begin
            ovf_d = 1'b0;
        end else if (wr_data && full) begin
            ovf_d = 1'b1;
        end
    end

    always_comb begin
        div_d = div_q;
        if (wr_div) begin
            for (int i = 0; i < DIV_W && i < 16; i++) begin
                if (io_wstrb[i/8]) begin
                    div_d[i] = io_wdata[i];
                end
            end
        end
    end

    always_comb begin
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (!push && pop) begin
            count_d = count_q - CW'(1);
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        pop     = 1'b0;
        case (state_q)
            StIdle: begin
                if (!empty) begin
                    pop     = 1'b1;
                    shift_d = mem[rptr_q];
                    cnt_d   = div_eff;
                    state_d = StStart;
                end
            end
            StStart: begin
                if (last) begin
                    cnt_d   = div_eff;
                    bit_d   = 3'd0;
                    state_d = StData;
                end else begin
                    cnt_d = cnt_q - DIV_W'(1);
                end
            end
            StData: begin
                if (last) begin
                    // Reload picks up any divisor written during the bit.
                    cnt_d   = div_eff;
                    shift_d = shift_q >> 1;
                    if (bit_q == 3'd7) begin
                        state_d = StStop;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q - DIV_W'(1);
                end
            end
            default: begin
                if (last) begin
                    if (!empty) begin
                        pop     = 1'b1;
                        shift_d = mem[rptr_q];
                        cnt_d   = div_eff;
                        state_d = StStart;
                    end else begin
                        state_d = StIdle;
                    end
                end else begin
                    cnt_d = cnt_q - DIV_W'(1);
                end
            end
        endcase
    end

    always_comb begin
        case (state_q)
            StStart: txd_d = 1'b0;
            StData:  txd_d = shift_q[0];
            default: txd_d = 1'b1;
        endcase
    end

    // Reads sample pre-write state, so a same-cycle write is not reflected.
    always_comb begin
        rdata_d = rdata_q;
        if (io_ren) begin
            case (io_raddr[3:2])
                2'd1:    rdata_d = status;
                2'd2:    rdata_d = 32'(div_q);
                default: rdata_d = 32'd0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr_q] <= io_wdata[7:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            div_q   <= DIV_W'(DIV_RESET);
            state_q <= StIdle;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            txd_q   <= 1'b1;
            rdata_q <= '0;
        end else begin
            if (push) begin
                wptr_q <= wptr_q + AW'(1);
            end
            if (pop) begin
                rptr_q <= rptr_q + AW'(1);
            end
            count_q <= count_d;
            ovf_q   <= ovf_d;
            div_q   <= div_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            txd_q   <= txd_d;
            rdata_q <= rdata_d;
        end
    end

    logic unused_bits;
    assign unused_bits = ^{io_raddr[31:4], io_raddr[1:0], io_waddr[31:4], io_waddr[1:0],
                           io_wdata[31:16], io_wstrb[3:2]};

endmodule
